pipeline_ctrl: RTL

- Central stall/flush controller for the 3-stage core (fetch, decode, execute/writeback).
- Generates per-stage clock enables, the decode-stage `invalidate` (bubble insert) and the fetch redirect flush.
- Handles post-reset hold, load-use hazards against the instruction entering decode, data-memory wait states, and taken-branch flushes.
- Keeps a saturating stall-cycle counter.

---
 rtl/pipeline_ctrl_if.sv | 28 ++
 rtl/pipeline_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the core datapath and the stall/flush controller.
// The master side is the core: it supplies hazard inputs and consumes the enables.
// The slave side is the controller.
interface pipeline_ctrl_if;
  logic [31:0] dec_inst;
  logic        dec_valid;
  logic [4:0]  ex_rd;
  logic        ex_is_load;
  logic        ex_valid;
  logic        ex_branch_taken;
  logic        mem_busy;
  logic        fetch_en;
  logic        decode_en;
  logic        execute_en;
  logic        invalidate;
  logic        flush;
  logic [15:0] stall_cnt;

  modport master (
    output dec_inst, dec_valid, ex_rd, ex_is_load, ex_valid, ex_branch_taken, mem_busy,
    input  fetch_en, decode_en, execute_en, invalidate, flush, stall_cnt
  );

  modport slave (
    input  dec_inst, dec_valid, ex_rd, ex_is_load, ex_valid, ex_branch_taken, mem_busy,
    output fetch_en, decode_en, execute_en, invalidate, flush, stall_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 3-stage core (fetch, decode, execute/writeback).
// Produces per-stage clock enables, the decode bubble request and the fetch redirect
// flush. Tracks post-reset hold, load-use hazards, memory wait states and branch
// flushes, and keeps a saturating count of stall cycles.
module pipeline_ctrl #(
  parameter bit RV32E           = 1'b0,
  parameter int RST_HOLD_CYCLES = 4,
  parameter int FLUSH_CYCLES    = 2
) (
  input logic           clk,
  input logic           sync_rst,
  pipeline_ctrl_if.slave bus
);

  // One down-counter serves both the reset hold and the flush window.
  localparam int CNT_MAX    = (RST_HOLD_CYCLES > FLUSH_CYCLES) ? RST_HOLD_CYCLES : FLUSH_CYCLES;
  localparam int CW         = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam int HOLD_LOAD  = RST_HOLD_CYCLES - 1;
  localparam int FLUSH_LOAD = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0;
  // RV32E only has 16 registers, so the top index bit is ignored.
  localparam logic [4:0] REG_MASK = RV32E ? 5'b01111 : 5'b11111;

  typedef enum logic [1:0] {HOLD, RUN, MEM_WAIT, FLUSH} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [15:0]   stall_q;
  logic          stall_inc;
  logic          fe, de, ee, inv, fl;

  logic [6:0] opc;
  logic [4:0] rd_m, rs1_m, rs2_m;
  logic       uses_rs1, uses_rs2, load_use;
  logic       unused_inst_bits;

  assign opc   = bus.dec_inst[6:0];
  assign rd_m  = bus.ex_rd & REG_MASK;
  assign rs1_m = bus.dec_inst[19:15] & REG_MASK;
  assign rs2_m = bus.dec_inst[24:20] & REG_MASK;
  assign unused_inst_bits = ^{bus.dec_inst[31:25], bus.dec_inst[14:7]};

  // LUI/AUIPC/JAL have no rs1; only BRANCH/STORE/OP read rs2.
  assign uses_rs1 = bus.dec_valid && !(opc inside {7'b0110111, 7'b0010111, 7'b1101111});
  assign uses_rs2 = bus.dec_valid &&  (opc inside {7'b1100011, 7'b0100011, 7'b0110011});

  // A load in execute whose result the decoding instruction needs (x0 never hazards).
  assign load_use = bus.ex_valid && bus.ex_is_load && (rd_m != 5'd0) &&
                    ((uses_rs1 && rd_m == rs1_m) || (uses_rs2 && rd_m == rs2_m));

  // State, shared counter and saturating stall counter.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state   <= HOLD;
      cnt     <= CW'(HOLD_LOAD);
      stall_q <= 16'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (stall_inc && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
  end

  // Next state and enables; reset forces the hold pattern whatever the state.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    stall_inc = 1'b0;
    fe = 1'b0; de = 1'b0; ee = 1'b0; inv = 1'b0; fl = 1'b0;
    if (sync_rst) begin
      inv = 1'b1;
    end else begin
      case (state)
        HOLD: begin
          inv = 1'b1;
          if (cnt == '0) state_n = RUN;
          else           cnt_n   = cnt - CW'(1);
        end
        RUN: begin
          if (bus.ex_branch_taken) begin
            fe = 1'b1; de = 1'b1; ee = 1'b1; inv = 1'b1; fl = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_n = FLUSH;
              cnt_n   = CW'(FLUSH_LOAD);
            end
          end else if (bus.mem_busy) begin
            stall_inc = 1'b1;
            state_n   = MEM_WAIT;
          end else if (load_use) begin
            ee = 1'b1; inv = 1'b1;
            stall_inc = 1'b1;
          end else begin
            fe = 1'b1; de = 1'b1; ee = 1'b1;
          end
        end
        MEM_WAIT: begin
          // Everything stays frozen, including the exit cycle; a branch in
          // execute is simply seen again once back in RUN.
          stall_inc = 1'b1;
          if (!bus.mem_busy) state_n = RUN;
        end
        FLUSH: begin
          if (bus.mem_busy) begin
            stall_inc = 1'b1;
          end else begin
            fe = 1'b1; de = 1'b1; ee = 1'b1; inv = 1'b1;
            if (cnt == '0) state_n = RUN;
            else           cnt_n   = cnt - CW'(1);
          end
        end
        default: state_n = HOLD;
      endcase
    end
  end

  assign bus.fetch_en   = fe;
  assign bus.decode_en  = de;
  assign bus.execute_en = ee;
  assign bus.invalidate = inv;
  assign bus.flush      = fl;
  assign bus.stall_cnt  = stall_q;

endmodule
